// File: rtl/mem_port_arbiter.sv
// Single-port memory bus arbiter for fetch (I) and load/store (D) requesters.
// D has priority; I is forced through after STARVE_MAX consecutive D grants.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_ack,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic            bus_err,
  output logic            busy
);

  localparam int BW = DW / 8;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] timeout_cnt;
  logic          timeout_hit;
  logic          force_i;
  logic          grant_d;
  logic          grant_i;

  assign timeout_hit = (timeout_cnt == TW'(TIMEOUT - 1));
  assign force_i     = i_req && (starve_cnt == SW'(STARVE_MAX));
  assign grant_d     = (state == IDLE) && d_req && !force_i;
  assign grant_i     = (state == IDLE) && i_req && !grant_d;

  // A timeout completes the transaction with zero data; mem_ready always wins.
  assign i_ack   = (state == BUSY_I) && (mem_ready || timeout_hit);
  assign d_ack   = (state == BUSY_D) && (mem_ready || timeout_hit);
  assign i_rdata = ((state == BUSY_I) && mem_ready) ? mem_rdata : '0;
  assign d_rdata = ((state == BUSY_D) && mem_ready) ? mem_rdata : '0;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      timeout_cnt <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      bus_err     <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state       <= BUSY_D;
            mem_req     <= 1'b1;
            mem_we      <= d_we;
            mem_be      <= d_be;
            mem_addr    <= d_addr;
            mem_wdata   <= d_wdata;
            timeout_cnt <= '0;
            // Count only D grants that bypassed a waiting fetch.
            if (!i_req)
              starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_MAX))
              starve_cnt <= starve_cnt + SW'(1);
          end else if (grant_i) begin
            state       <= BUSY_I;
            mem_req     <= 1'b1;
            mem_we      <= 1'b0;
            mem_be      <= {BW{1'b1}};
            mem_addr    <= i_addr;
            mem_wdata   <= '0;
            timeout_cnt <= '0;
            starve_cnt  <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end else if (timeout_hit) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            bus_err <= 1'b1;
          end else begin
            timeout_cnt <= timeout_cnt + TW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
